// File: rtl/generador_pwm_pkg.sv
// Shared types and default sizing for the generador_pwm PWM generator.
// Optional feature macro: GENERADOR_PWM_SYNC_EN (see detector_flanco).
package generador_pwm_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PERIOD_MAX = (1 << DEF_WIDTH) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/generador_pwm_detector_flanco.sv
// Rising-edge detector turning the divider's square wave into a one-cycle tick.
// GENERADOR_PWM_SYNC_EN defined: a 2-flop synchronizer precedes edge detection.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic tick
);

  logic cur;
  logic prev_d;
  logic prev_q;

`ifdef GENERADOR_PWM_SYNC_EN
  logic [1:0] sync_d;
  logic [1:0] sync_q;

  always_comb sync_d = {sync_q[0], sig_in};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign cur = sync_q[1];
`else
  assign cur = sig_in;
`endif

  always_comb prev_d = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign tick = cur & ~prev_q;

endmodule

// File: rtl/generador_pwm.sv
// Tick-driven PWM generator with a double-buffered duty value applied at period boundaries.
// Build option GENERADOR_PWM_SYNC_EN adds a Clock_div synchronizer (in detector_flanco).
module generador_pwm
  import generador_pwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PERIOD_MAX = (1 << WIDTH) - 1
) (
  input  logic           Clock_in,
  input  logic           Reset_n,
  input  logic           Clock_div,
  input  logic           Enable,
  input  logic [WIDTH:0] Duty,
  input  logic           Duty_load,
  output logic           PWM_out,
  output logic           Period_end,
  output logic           Duty_ack
);

  localparam logic [WIDTH:0]   DUTY_FULL = (WIDTH + 1)'(PERIOD_MAX + 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(PERIOD_MAX);

  logic tick;

  state_e           state_d,       state_q;
  logic [WIDTH-1:0] counter_d,     counter_q;
  logic [WIDTH:0]   duty_active_d, duty_active_q;
  logic [WIDTH:0]   duty_shadow_d, duty_shadow_q;
  logic             pending_d,     pending_q;
  logic             pwm_d,         pwm_q;
  logic             period_end_d,  period_end_q;
  logic             duty_ack_d,    duty_ack_q;

  logic             wrap;
  logic [WIDTH-1:0] counter_next;
  logic [WIDTH:0]   duty_clamped;
  logic             apply;
  logic             run_step;

  detector_flanco u_detector_flanco (
    .clk    (Clock_in),
    .rst_n  (Reset_n),
    .sig_in (Clock_div),
    .tick   (tick)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    counter_d     = counter_q;
    duty_active_d = duty_active_q;
    duty_shadow_d = duty_shadow_q;
    pending_d     = pending_q;
    pwm_d         = pwm_q;
    period_end_d  = 1'b0;
    duty_ack_d    = 1'b0;
    apply         = 1'b0;
    run_step      = 1'b0;

    wrap         = (counter_q == CNT_LAST);
    counter_next = wrap ? '0 : counter_q + WIDTH'(1);
    duty_clamped = (Duty > DUTY_FULL) ? DUTY_FULL : Duty;

    case (state_q)
      IDLE: begin
        counter_d = '0;
        pwm_d     = 1'b0;
        if (Enable) begin
          state_d = RUN;
          apply   = 1'b1;
        end
      end
      RUN: begin
        if (!Enable) begin
          state_d   = IDLE;
          counter_d = '0;
          pwm_d     = 1'b0;
        end else if (tick) begin
          run_step     = 1'b1;
          counter_d    = counter_next;
          period_end_d = wrap;
          apply        = wrap & pending_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply) begin
      duty_active_d = duty_shadow_q;
      pending_d     = 1'b0;
      duty_ack_d    = pending_q;
    end

    // A load on the applying edge lands in the shadow and waits for the next boundary.
    if (Duty_load) begin
      duty_shadow_d = duty_clamped;
      pending_d     = 1'b1;
    end

    if (run_step) begin
      pwm_d = ({1'b0, counter_next} < duty_active_d);
    end
  end

  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      duty_active_q <= '0;
      duty_shadow_q <= '0;
      pending_q     <= 1'b0;
      pwm_q         <= 1'b0;
      period_end_q  <= 1'b0;
      duty_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      duty_active_q <= duty_active_d;
      duty_shadow_q <= duty_shadow_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      period_end_q  <= period_end_d;
      duty_ack_q    <= duty_ack_d;
    end
  end

  assign PWM_out    = pwm_q;
  assign Period_end = period_end_q;
  assign Duty_ack   = duty_ack_q;

endmodule

// File: tb/tb_generador_pwm.sv
// Scoreboard bench for generador_pwm: a tick-level model queues expected outputs per event.
module tb_generador_pwm;

  localparam int WIDTH      = 8;
  localparam int PERIOD_MAX = 255;
`ifdef GENERADOR_PWM_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic           Clock_in;
  logic           Reset_n;
  logic           Clock_div;
  logic           Enable;
  logic [WIDTH:0] Duty;
  logic           Duty_load;
  logic           PWM_out;
  logic           Period_end;
  logic           Duty_ack;

  typedef struct {
    logic pwm;
    logic pe;
    logic ack;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int pe_seen;
  int ack_seen;
  int high_seen;

  int m_cnt;
  int m_active;
  int m_shadow;
  bit m_run;
  bit m_pending;
  bit m_pwm;

  generador_pwm #(
    .WIDTH      (WIDTH),
    .PERIOD_MAX (PERIOD_MAX)
  ) dut (
    .Clock_in   (Clock_in),
    .Reset_n    (Reset_n),
    .Clock_div  (Clock_div),
    .Enable     (Enable),
    .Duty       (Duty),
    .Duty_load  (Duty_load),
    .PWM_out    (PWM_out),
    .Period_end (Period_end),
    .Duty_ack   (Duty_ack)
  );

  initial Clock_in = 1'b0;
  always #5 Clock_in = ~Clock_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int clamp(input int dv);
    return (dv > PERIOD_MAX + 1) ? PERIOD_MAX + 1 : dv;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_active = 0; m_shadow = 0;
    m_run = 1'b0; m_pending = 1'b0; m_pwm = 1'b0;
  endfunction

  // Expected outputs right after one Clock_div tick (with an optional same-cycle load).
  function automatic exp_t model_tick(input bit ld, input int dv);
    exp_t e;
    e.pe  = 1'b0;
    e.ack = 1'b0;
    if (m_run) begin
      if (m_cnt == PERIOD_MAX) begin
        m_cnt = 0;
        e.pe  = 1'b1;
        if (m_pending) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
          e.ack     = 1'b1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_pwm = (m_cnt < m_active);
    end
    if (ld) begin
      m_shadow  = clamp(dv);
      m_pending = 1'b1;
    end
    e.pwm = m_pwm;
    return e;
  endfunction

  task automatic clear_seen();
    pe_seen = 0; ack_seen = 0; high_seen = 0;
  endtask

  // One full Clock_div pulse (high then low); entered and left at posedge+1.
  task automatic tick(input string tag, input bit ld, input int dv);
    exp_t e;
    sb_q.push_back(model_tick(ld, dv));
    Clock_div = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      @(posedge Clock_in); #1;
    end
    if (ld) begin
      Duty      = (WIDTH + 1)'(dv);
      Duty_load = 1'b1;
    end
    @(posedge Clock_in);
    @(negedge Clock_in);
    Duty_load = 1'b0;
    if (PWM_out === 1'b1) high_seen++;
    if (Period_end === 1'b1) pe_seen++;
    if (Duty_ack === 1'b1) ack_seen++;
    e = sb_q.pop_front();
    checks++;
    if ({PWM_out, Period_end, Duty_ack} !== {e.pwm, e.pe, e.ack}) begin
      errors++;
      $display("FAIL %s: pwm/pe/ack got %b%b%b expected %b%b%b", tag,
               PWM_out, Period_end, Duty_ack, e.pwm, e.pe, e.ack);
    end
    @(posedge Clock_in); #1;
    Clock_div = 1'b0;
    @(negedge Clock_in);
    checks++;
    if ({Period_end, Duty_ack} !== 2'b00) begin
      errors++;
      $display("FAIL %s_pulse_width: pe/ack got %b%b expected 00", tag, Period_end, Duty_ack);
    end
    @(posedge Clock_in); #1;
    @(posedge Clock_in); #1;
  endtask

  task automatic run_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 0);
  endtask

  task automatic load_duty(input int dv);
    m_shadow  = clamp(dv);
    m_pending = 1'b1;
    Duty      = (WIDTH + 1)'(dv);
    Duty_load = 1'b1;
    @(posedge Clock_in); #1;
    Duty_load = 1'b0;
  endtask

  task automatic enable_on(input string tag, input bit ld, input int dv);
    exp_t e;
    e.pwm = 1'b0;
    e.pe  = 1'b0;
    e.ack = m_pending;
    m_run = 1'b1; m_cnt = 0; m_pwm = 1'b0;
    m_active = m_shadow; m_pending = 1'b0;
    if (ld) begin
      m_shadow  = clamp(dv);
      m_pending = 1'b1;
    end
    sb_q.push_back(e);
    Enable = 1'b1;
    if (ld) begin
      Duty      = (WIDTH + 1)'(dv);
      Duty_load = 1'b1;
    end
    @(posedge Clock_in);
    @(negedge Clock_in);
    Duty_load = 1'b0;
    if (Duty_ack === 1'b1) ack_seen++;
    e = sb_q.pop_front();
    checks++;
    if ({PWM_out, Period_end, Duty_ack} !== {e.pwm, e.pe, e.ack}) begin
      errors++;
      $display("FAIL %s: pwm/pe/ack got %b%b%b expected %b%b%b", tag,
               PWM_out, Period_end, Duty_ack, e.pwm, e.pe, e.ack);
    end
    @(posedge Clock_in); #1;
  endtask

  task automatic enable_off(input string tag);
    exp_t e;
    e.pwm = 1'b0; e.pe = 1'b0; e.ack = 1'b0;
    m_run = 1'b0; m_cnt = 0; m_pwm = 1'b0;
    sb_q.push_back(e);
    Enable = 1'b0;
    @(posedge Clock_in);
    @(negedge Clock_in);
    if (Period_end === 1'b1) pe_seen++;
    e = sb_q.pop_front();
    checks++;
    if ({PWM_out, Period_end, Duty_ack} !== {e.pwm, e.pe, e.ack}) begin
      errors++;
      $display("FAIL %s: pwm/pe/ack got %b%b%b expected %b%b%b", tag,
               PWM_out, Period_end, Duty_ack, e.pwm, e.pe, e.ack);
    end
    @(posedge Clock_in); #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; Clock_div = 1'b0; Enable = 1'b0; Duty = '0; Duty_load = 1'b0;
    model_reset();
    #1 Reset_n = 1'b0;
    #2;
    checks++;
    if ({PWM_out, Period_end, Duty_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b expected 000", PWM_out, Period_end, Duty_ack);
    end
    @(posedge Clock_in); @(posedge Clock_in); #1;
    Reset_n = 1'b1;
    @(posedge Clock_in); #1;
    tick("idle_tick_ignored", 1'b0, 0);
  endtask

  task automatic test_duty64();
    load_duty(64);
    clear_seen();
    enable_on("en_duty64", 1'b0, 0);
    run_ticks("duty64", 512);
    checks++;
    if (high_seen != 128) begin
      errors++;
      $display("FAIL duty64_high_ticks: got %0d expected 128", high_seen);
    end
    checks++;
    if (pe_seen != 2) begin
      errors++;
      $display("FAIL duty64_period_end_count: got %0d expected 2", pe_seen);
    end
    checks++;
    if (ack_seen != 1) begin
      errors++;
      $display("FAIL duty64_ack_count: got %0d expected 1", ack_seen);
    end
  endtask

  task automatic test_boundary();
    int dvals [3] = '{0, 256, 300};
    int highs [3] = '{0, 256, 256};
    for (int k = 0; k < 3; k++) begin
      enable_off("bnd_off");
      load_duty(dvals[k]);
      enable_on("bnd_en", 1'b0, 0);
      clear_seen();
      run_ticks("bnd", 256);
      checks++;
      if (high_seen != highs[k]) begin
        errors++;
        $display("FAIL boundary_duty_%0d_high: got %0d expected %0d", dvals[k], high_seen, highs[k]);
      end
    end
  endtask

  task automatic test_midperiod();
    enable_off("mid_off");
    load_duty(64);
    enable_on("mid_en", 1'b0, 0);
    run_ticks("mid_a", 100);
    load_duty(128);
    run_ticks("mid_b", 155);
    clear_seen();
    run_ticks("mid_c", 256);
    checks++;
    if (high_seen != 128 || pe_seen != 1 || ack_seen != 1) begin
      errors++;
      $display("FAIL midperiod_next_period: high/pe/ack got %0d/%0d/%0d expected 128/1/1",
               high_seen, pe_seen, ack_seen);
    end
  endtask

  task automatic test_simultaneous();
    load_duty(200);
    tick("wrap_with_load", 1'b1, 32);
    run_ticks("simul_a", 255);
    clear_seen();
    tick("wrap_applies_32", 1'b0, 0);
    checks++;
    if (ack_seen != 1) begin
      errors++;
      $display("FAIL simultaneous_second_ack: got %0d expected 1", ack_seen);
    end
    enable_off("simul_off");
    enable_on("enable_with_load", 1'b1, 16);
    run_ticks("simul_b", 256);
  endtask

  task automatic test_enable_drop();
    enable_off("drop_off0");
    load_duty(100);
    enable_on("drop_en", 1'b0, 0);
    run_ticks("drop_a", 50);
    clear_seen();
    enable_off("drop_at_50");
    tick("drop_idle_tick", 1'b0, 0);
    enable_on("drop_reen", 1'b0, 0);
    run_ticks("drop_b", 120);
    checks++;
    if (pe_seen != 0) begin
      errors++;
      $display("FAIL drop_no_period_end: got %0d expected 0", pe_seen);
    end
  endtask

  task automatic test_reset_mid();
    enable_off("rst_off0");
    load_duty(200);
    enable_on("rst_en", 1'b0, 0);
    run_ticks("rst_a", 100);
    #2;
    Enable  = 1'b0;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({PWM_out, Period_end, Duty_ack} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_mid_run: got %b%b%b expected 000", PWM_out, Period_end, Duty_ack);
    end
    @(posedge Clock_in); #1;
    Reset_n = 1'b1;
    model_reset();
    @(posedge Clock_in); #1;
    tick("post_reset_idle", 1'b0, 0);
    enable_on("post_reset_en", 1'b0, 0);
    run_ticks("post_reset_run", 3);
  endtask

  task automatic test_latency();
    exp_t e;
    int   lat;
    enable_off("lat_off");
    load_duty(2);
    enable_on("lat_en", 1'b0, 0);
    sb_q.push_back(model_tick(1'b0, 0));
    lat = 0;
    Clock_div = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge Clock_in);
      @(negedge Clock_in);
      if (lat == 0 && PWM_out === 1'b1) lat = n;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL tick_latency: got %0d cycles expected %0d (0 means no update seen)", lat, LAT);
    end
    e = sb_q.pop_front();
    checks++;
    if (PWM_out !== e.pwm) begin
      errors++;
      $display("FAIL latency_pwm: got %b expected %b", PWM_out, e.pwm);
    end
    @(posedge Clock_in); #1;
    Clock_div = 1'b0;
    @(posedge Clock_in); #1;
    @(posedge Clock_in); #1;
    enable_off("lat_end");
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_boundary();
    test_midperiod();
    test_simultaneous();
    test_enable_drop();
    test_reset_mid();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
